gadget_catcher: RTL



---
 rtl/gadget_catcher_if.sv | 40 ++++
 rtl/gadget_catcher.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/gadget_catcher_if.sv
// ---------------------------------------------------------------------------
// gadget_catcher_if
// Link between the catcher and the falling-gadget stage.
//
// Handshake (one rule for every transfer on this link):
//   gadget_req   - one-cycle step request from the catcher.
//   gadget_ack   - the gadget stage took a step; gadgetX/gadgetY/gadget_type
//                  are valid in this same cycle and only in this cycle.
//   gadget_frame_term - the gadget stage has no more steps this frame; it
//                  wins over gadget_ack when both are high.
//   gadget_eaten - one-cycle pulse telling the gadget stage to clear its
//                  gadget (caught or missed).
//
// Modports:
//   master - catcher side (drives req/eaten)
//   slave  - gadget stage side (drives ack/frame_term/position/type)
// ---------------------------------------------------------------------------
interface gadget_catcher_if #(
  parameter int PIXELX_W = 10,
  parameter int PIXELY_W = 9,
  parameter int TYPE_W   = 4
);
  logic                gadget_req;
  logic                gadget_eaten;
  logic                gadget_ack;
  logic                gadget_frame_term;
  logic [PIXELX_W-1:0] gadgetX;
  logic [PIXELY_W-1:0] gadgetY;
  logic [TYPE_W-1:0]   gadget_type;

  modport master (
    output gadget_req, gadget_eaten,
    input  gadget_ack, gadget_frame_term, gadgetX, gadgetY, gadget_type
  );

  modport slave (
    input  gadget_req, gadget_eaten,
    output gadget_ack, gadget_frame_term, gadgetX, gadgetY, gadget_type
  );
endinterface

// File: rtl/gadget_catcher.sv
// ---------------------------------------------------------------------------
// gadget_catcher
// Once per frame, steps the falling-gadget stage with a burst of requests,
// tests each acknowledged position against the paddle rectangle and the
// screen bottom, clears the gadget on a catch or miss, and runs a
// frame-counted power-up effect timer after a catch.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   i_cal_frame       - one-cycle frame-start pulse
//   i_game_start      - synchronous clear, same effect as rst
//   gbus (master)     - req/ack/frame_term/eaten link to the gadget stage
//   i_paddleX/Y       - paddle centre X, paddle top Y
//   o_caught/o_missed - one-cycle result pulses
//   o_frame_done      - one-cycle pulse when the frame's sequence ends
//   o_effect_type     - active effect type (0 = none)
//   o_effect_active   - effect timer nonzero
//   o_overrun         - sticky: frame pulse arrived while busy
//   o_dbg_state       - FSM state (IDLE=0 REQ=1 WAIT=2 CHECK=3 DONE=4)
//   o_dbg_timer       - effect timer value
//
// Optional feature macro: GADGET_EFFECT_STACK_EN
//   defined   - catching the active effect type adds EFFECT_FRAMES to the
//               timer (saturating at 16'hFFFF); another type reloads it.
//   undefined - every catch reloads the timer to EFFECT_FRAMES.
// ---------------------------------------------------------------------------
module gadget_catcher #(
  parameter int PIXELX_W      = 10,
  parameter int PIXELY_W      = 9,
  parameter int TYPE_W        = 4,
  parameter int GADGET_SIZE   = 8,
  parameter int PADDLE_HALF_W = 32,
  parameter int PADDLE_H      = 8,
  parameter int SCREEN_BOTTOM = 470,
  parameter int MAX_STEPS     = 31,
  parameter int WAIT_LIMIT    = 4,
  parameter int EFFECT_FRAMES = 600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_cal_frame,
  input  logic                 i_game_start,
  gadget_catcher_if.master     gbus,
  input  logic [PIXELX_W-1:0]  i_paddleX,
  input  logic [PIXELY_W-1:0]  i_paddleY,
  output logic                 o_caught,
  output logic                 o_missed,
  output logic                 o_frame_done,
  output logic [TYPE_W-1:0]    o_effect_type,
  output logic                 o_effect_active,
  output logic                 o_overrun,
  output logic [2:0]           o_dbg_state,
  output logic [15:0]          o_dbg_timer
);

  localparam int STEP_W = $clog2(MAX_STEPS + 1);
  localparam int WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;

  // Geometry constants one bit wider than the pixel buses so sums never wrap.
  localparam logic [PIXELX_W:0] HALF_X = (PIXELX_W+1)'(PADDLE_HALF_W);
  localparam logic [PIXELX_W:0] SIZE_X = (PIXELX_W+1)'(GADGET_SIZE);
  localparam logic [PIXELY_W:0] SIZE_Y = (PIXELY_W+1)'(GADGET_SIZE);
  localparam logic [PIXELY_W:0] PH_Y   = (PIXELY_W+1)'(PADDLE_H);
  localparam logic [PIXELY_W:0] BOT_Y  = (PIXELY_W+1)'(SCREEN_BOTTOM);
  localparam logic [15:0]       EFFECT_T  = 16'(EFFECT_FRAMES);
  localparam logic [STEP_W-1:0] STEP_MAX  = STEP_W'(MAX_STEPS);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   step_q;
  logic [WAIT_W-1:0]   wait_q;
  logic [15:0]         timer_q;

  logic clr_cnts, inc_step, inc_wait, clr_wait, catch_now, miss_now;
  logic [15:0] timer_dec, timer_load;

  // Hit test on the position presented with gadget_ack; the registered
  // result (o_caught/o_missed) is what CHECK acts on.
  logic [PIXELX_W:0] px_e, gx_e, left_x, right_x;
  logic [PIXELY_W:0] py_e, gy_e;
  logic              hit_c, low_c;

  assign px_e    = {1'b0, i_paddleX};
  assign gx_e    = {1'b0, gbus.gadgetX};
  assign py_e    = {1'b0, i_paddleY};
  assign gy_e    = {1'b0, gbus.gadgetY};
  assign left_x  = (px_e >= HALF_X) ? (px_e - HALF_X) : '0;
  assign right_x = px_e + HALF_X;
  assign hit_c   = (gbus.gadget_type != '0) &&
                   ((gx_e + SIZE_X) >= left_x) && (gx_e <= right_x) &&
                   ((gy_e + SIZE_Y) >= py_e) && (gy_e <= (py_e + PH_Y));
  assign low_c   = (gy_e >= BOT_Y);

  always_comb begin
    state_d   = state_q;
    clr_cnts  = 1'b0;
    inc_step  = 1'b0;
    inc_wait  = 1'b0;
    clr_wait  = 1'b0;
    catch_now = 1'b0;
    miss_now  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_cal_frame) begin
          clr_cnts = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        inc_step = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (gbus.gadget_frame_term) begin
          state_d = S_DONE;
        end else if (gbus.gadget_ack) begin
          catch_now = hit_c;
          miss_now  = !hit_c && low_c;
          state_d   = S_CHECK;
        end else if (wait_q == WAIT_LAST) begin
          clr_wait = 1'b1;
          state_d  = S_REQ;
        end else begin
          inc_wait = 1'b1;
        end
      end
      S_CHECK: begin
        if (o_caught || o_missed)  state_d = S_DONE;
        else if (step_q == STEP_MAX) state_d = S_DONE;
        else                        state_d = S_REQ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Effect timer candidates: per-frame decrement and the value a catch loads.
  always_comb begin
    timer_dec = timer_q;
    if (i_cal_frame && (timer_q != 16'd0)) timer_dec = timer_q - 16'd1;
    timer_load = EFFECT_T;
`ifdef GADGET_EFFECT_STACK_EN
    if (gbus.gadget_type == o_effect_type) begin
      logic [16:0] stack_sum;
      stack_sum  = {1'b0, timer_q} + {1'b0, EFFECT_T};
      timer_load = stack_sum[16] ? 16'hFFFF : stack_sum[15:0];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst || i_game_start) begin
      state_q           <= S_IDLE;
      step_q            <= '0;
      wait_q            <= '0;
      timer_q           <= '0;
      gbus.gadget_req   <= 1'b0;
      gbus.gadget_eaten <= 1'b0;
      o_caught          <= 1'b0;
      o_missed          <= 1'b0;
      o_frame_done      <= 1'b0;
      o_effect_type     <= '0;
      o_overrun         <= 1'b0;
    end else begin
      state_q <= state_d;

      // Saturates so heavy re-issuing can never skip past the cap.
      if (clr_cnts)                        step_q <= '0;
      else if (inc_step && step_q != STEP_MAX) step_q <= step_q + 1'b1;

      if (clr_cnts || clr_wait) wait_q <= '0;
      else if (inc_wait)        wait_q <= wait_q + 1'b1;

      // Pulses are flops keyed off the next state / this cycle's decision.
      gbus.gadget_req   <= (state_d == S_REQ);
      o_frame_done      <= (state_d == S_DONE);
      o_caught          <= catch_now;
      o_missed          <= miss_now;
      gbus.gadget_eaten <= catch_now || miss_now;

      if (i_cal_frame && (state_q != S_IDLE)) o_overrun <= 1'b1;

      // A catch in the same cycle as a frame decrement takes the catch value.
      if (catch_now) begin
        timer_q       <= timer_load;
        o_effect_type <= gbus.gadget_type;
      end else begin
        timer_q <= timer_dec;
        if (timer_dec == 16'd0) o_effect_type <= '0;
      end
    end
  end

  assign o_effect_active = (timer_q != 16'd0);
  assign o_dbg_state     = state_q;
  assign o_dbg_timer     = timer_q;

endmodule
